// File: rtl/exe_pipe_stage_pkg.sv
// Shared definitions for the execute pipeline stage: command encodings,
// shift-type codes, status bit positions and the sequencing state enum.
// Optional multiplier support is selected with the EXE_MUL_EN macro.
package exe_pipe_stage_pkg;

  // Operation encodings carried on exe_cmd
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  // Register-operand shift types (shift_operand[6:5])
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Bit positions inside status = {N,Z,C,V}
  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  // IDLE: output register empty; FULL: result waiting for MEM;
  // MUL: iterative multiply running (only exists with EXE_MUL_EN)
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FULL = 2'd1
`ifdef EXE_MUL_EN
    , S_MUL = 2'd2
`endif
  } exe_state_t;

endpackage

// File: rtl/exe_alu.sv
// Combinational execute datapath: second-operand (Val2) generation, the
// ALU proper and the candidate {N,Z,C,V} flags. Unknown commands yield a
// zero result and pass the incoming flags through unchanged.
module exe_alu
  import exe_pipe_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        exe_cmd,
  input  logic              imm,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [11:0]       shift_operand,
  input  logic [3:0]        status_in,
  output logic [DATA_W-1:0] val2,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [2*DATA_W-1:0] rot_src;
  logic [SH_W-1:0]     rot_amt;
  logic [4:0]          sh_amt;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   opb;
  logic                cin;
  logic                is_arith;
  logic                known;

  // Val2: rotated immediate, raw 12-bit memory offset, or shifted register.
  // Rotates use a doubled copy so the low half holds the wrapped value.
  always_comb begin
    val2    = '0;
    rot_src = '0;
    rot_amt = '0;
    sh_amt  = shift_operand[11:7];
    if (imm) begin
      rot_amt = SH_W'({shift_operand[11:8], 1'b0});
      rot_src = {2{DATA_W'(shift_operand[7:0])}};
      rot_src = rot_src >> rot_amt;
      val2    = rot_src[DATA_W-1:0];
    end else if (mem_r_en || mem_w_en) begin
      val2 = DATA_W'(shift_operand);
    end else begin
      case (shift_operand[6:5])
        SH_LSL:  val2 = val_rm << sh_amt;
        SH_LSR:  val2 = val_rm >> sh_amt;
        SH_ASR:  val2 = $signed(val_rm) >>> sh_amt;
        default: begin
          rot_src = {val_rm, val_rm} >> SH_W'(sh_amt);
          val2    = rot_src[DATA_W-1:0];
        end
      endcase
    end
  end

  // ALU and flags. Subtraction is rn + ~val2 + cin so the carry out is
  // directly the "no borrow" flag.
  always_comb begin
    result   = '0;
    flags    = status_in;
    opb      = val2;
    cin      = 1'b0;
    is_arith = 1'b0;
    known    = 1'b1;
    case (exe_cmd)
      CMD_MOV: result = val2;
      CMD_MVN: result = ~val2;
      CMD_ADD: is_arith = 1'b1;
      CMD_ADC: begin
        is_arith = 1'b1;
        cin      = status_in[ST_C];
      end
      CMD_SUB: begin
        is_arith = 1'b1;
        opb      = ~val2;
        cin      = 1'b1;
      end
      CMD_SBC: begin
        is_arith = 1'b1;
        opb      = ~val2;
        cin      = status_in[ST_C];
      end
      CMD_AND: result = val_rn & val2;
      CMD_ORR: result = val_rn | val2;
      CMD_EOR: result = val_rn ^ val2;
      default: known = 1'b0;
    endcase
    sum = {1'b0, val_rn} + {1'b0, opb} + {{DATA_W{1'b0}}, cin};
    if (is_arith) result = sum[DATA_W-1:0];
    if (known) begin
      flags[ST_N] = result[MSB];
      flags[ST_Z] = (result == '0);
      if (is_arith) begin
        flags[ST_C] = sum[DATA_W];
        flags[ST_V] = (val_rn[MSB] == opb[MSB]) && (result[MSB] != val_rn[MSB]);
      end
    end
  end

endmodule

// File: rtl/exe_pipe_stage.sv
// Execute pipeline stage: one-entry output register toward MEM with a
// valid/ready handshake, status register, and optional iterative
// multiplier enabled by the EXE_MUL_EN macro.
//
// Handshake: an operation is accepted when in_valid && in_ready at a rising
// edge (in_ready = !busy && (!out_valid || out_ready) && !flush); a result
// leaves when out_valid && out_ready at a rising edge. Outputs hold while
// out_valid && !out_ready. flush wins over any accept.
module exe_pipe_stage
  import exe_pipe_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        exe_cmd,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic              imm,
  input  logic              s_bit,
  input  logic [REG_W-1:0]  dest,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [11:0]       shift_operand,
  input  logic [23:0]       signed_imm_24,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en_o,
  output logic              mem_r_en_o,
  output logic              mem_w_en_o,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] st_val,
  output logic [DATA_W-1:0] br_addr,
  output logic [REG_W-1:0]  dest_o,
  output logic [3:0]        status,
  output logic              busy,
  output exe_state_t        state
);

  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flags;
  logic [DATA_W-1:0] br_off;
  logic              accept;

  // Word offset: sign-extend the 24-bit field and scale by 4
  assign br_off   = DATA_W'({{DATA_W{signed_imm_24[23]}}, signed_imm_24, 2'b00});
  assign in_ready = !busy && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

`ifdef EXE_MUL_EN
  localparam int CNT_W = $clog2(DATA_W);
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] mul_acc;
  logic [DATA_W-1:0] mul_mcand;
  logic [DATA_W-1:0] mul_mplier;
  logic [DATA_W-1:0] acc_next;
  logic [CNT_W-1:0]  mul_cnt;
  logic              mul_s;

  assign acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign busy     = (state == S_MUL);
`else
  assign busy = 1'b0;
`endif

  exe_alu #(.DATA_W(DATA_W)) u_alu (
    .exe_cmd       (exe_cmd),
    .imm           (imm),
    .mem_r_en      (mem_r_en),
    .mem_w_en      (mem_w_en),
    .val_rn        (val_rn),
    .val_rm        (val_rm),
    .shift_operand (shift_operand),
    .status_in     (status),
`ifdef EXE_MUL_EN
    .val2          (val2),
`else
    .val2          (),
`endif
    .result        (alu_res),
    .flags         (alu_flags)
  );

  // Sequencer and output registers: flush > accept > multiply step > drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      wb_en_o    <= 1'b0;
      mem_r_en_o <= 1'b0;
      mem_w_en_o <= 1'b0;
      alu_result <= '0;
      st_val     <= '0;
      br_addr    <= '0;
      dest_o     <= '0;
      status     <= 4'b0000;
`ifdef EXE_MUL_EN
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
      mul_s      <= 1'b0;
`endif
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      wb_en_o    <= wb_en;
      mem_r_en_o <= mem_r_en;
      mem_w_en_o <= mem_w_en;
      dest_o     <= dest;
      st_val     <= val_rm;
      br_addr    <= pc + br_off;
`ifdef EXE_MUL_EN
      if (exe_cmd == CMD_MUL) begin
        state      <= S_MUL;
        out_valid  <= 1'b0;
        mul_acc    <= '0;
        mul_mcand  <= val_rn;
        mul_mplier <= val2;
        mul_cnt    <= '0;
        mul_s      <= s_bit;
      end else
`endif
      begin
        state      <= S_FULL;
        out_valid  <= 1'b1;
        alu_result <= alu_res;
        if (s_bit) status <= alu_flags;
      end
`ifdef EXE_MUL_EN
    end else if (state == S_MUL) begin
      // One multiplier bit per cycle; the last step lands in FULL
      mul_acc    <= acc_next;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + 1'b1;
      if (mul_cnt == CNT_W'(DATA_W - 1)) begin
        state      <= S_FULL;
        out_valid  <= 1'b1;
        alu_result <= acc_next;
        if (mul_s) begin
          status[ST_N] <= acc_next[DATA_W-1];
          status[ST_Z] <= (acc_next == '0);
        end
      end
`endif
    end else if (out_valid && out_ready) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_pipe_stage.sv
// Self-checking bench for exe_pipe_stage (default DATA_W=32, REG_W=4).
// Multiply scenarios are compiled in when EXE_MUL_EN is defined.
module tb_exe_pipe_stage;
  import exe_pipe_stage_pkg::*;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam longint MAXS = (64'sd1 <<< (DW - 1)) - 64'sd1;
  localparam longint MINS = -(64'sd1 <<< (DW - 1));

  typedef struct {
    logic [3:0]    cmd;
    logic          wb, mr, mw, imm, s;
    logic [RW-1:0] dest;
    logic [DW-1:0] pc, rn, rm;
    logic [11:0]   shop;
    logic [23:0]   simm;
  } op_t;

  typedef struct {
    logic [DW-1:0] res, st, br;
    logic [RW-1:0] dest;
    logic          wb, mr, mw;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0, in_ready;
  logic [3:0]        exe_cmd = '0;
  logic              wb_en = 1'b0, mem_r_en = 1'b0, mem_w_en = 1'b0, imm = 1'b0, s_bit = 1'b0;
  logic [RW-1:0]     dest = '0;
  logic [DW-1:0]     pc = '0, val_rn = '0, val_rm = '0;
  logic [11:0]       shift_operand = '0;
  logic [23:0]       signed_imm_24 = '0;
  logic              flush = 1'b0, out_valid, out_ready = 1'b0;
  logic              wb_en_o, mem_r_en_o, mem_w_en_o, busy;
  logic [DW-1:0]     alu_result, st_val, br_addr;
  logic [RW-1:0]     dest_o;
  logic [3:0]        status;
  exe_state_t        state;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [3:0] mdl_status = 4'b0000;

  exe_pipe_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .imm(imm), .s_bit(s_bit), .dest(dest), .pc(pc), .val_rn(val_rn),
    .val_rm(val_rm), .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .wb_en_o(wb_en_o), .mem_r_en_o(mem_r_en_o), .mem_w_en_o(mem_w_en_o),
    .alu_result(alu_result), .st_val(st_val), .br_addr(br_addr),
    .dest_o(dest_o), .status(status), .busy(busy), .state(state)
  );

  // ---------------- reference model (bit-serial shifts, wide arithmetic)
  function automatic void ref_op(input op_t o, input logic [3:0] st_in,
                                 output exp_t e, output logic [3:0] st_out);
    logic [DW-1:0] v2, r;
    longint unsigned ua, ub, full, cu;
    longint sa, sb, sr, cs;
    logic c, v, known;
    int amt;
    if (o.imm) begin
      v2 = {24'd0, o.shop[7:0]};
      amt = 2 * int'(o.shop[11:8]);
      for (int i = 0; i < amt; i++) v2 = {v2[0], v2[DW-1:1]};
    end else if (o.mr || o.mw) begin
      v2 = {20'd0, o.shop};
    end else begin
      v2 = o.rm;
      amt = int'(o.shop[11:7]);
      for (int i = 0; i < amt; i++) begin
        case (o.shop[6:5])
          2'd0:    v2 = {v2[DW-2:0], 1'b0};
          2'd1:    v2 = {1'b0, v2[DW-1:1]};
          2'd2:    v2 = {v2[DW-1], v2[DW-1:1]};
          default: v2 = {v2[0], v2[DW-1:1]};
        endcase
      end
    end
    ua = longint'(o.rn);
    ub = longint'(v2);
    sa = longint'($signed(o.rn));
    sb = longint'($signed(v2));
    c = st_in[1];
    v = st_in[0];
    known = 1'b1;
    r = '0;
    case (o.cmd)
      4'b0001: r = v2;
      4'b1001: r = ~v2;
      4'b0010, 4'b0011: begin
        cu = (o.cmd == 4'b0011) ? longint'(st_in[1]) : 0;
        cs = longint'(cu);
        full = ua + ub + cu;
        r = full[DW-1:0];
        c = full[DW];
        sr = sa + sb + cs;
        v = (sr > MAXS) || (sr < MINS);
      end
      4'b0100, 4'b0101: begin
        cu = (o.cmd == 4'b0101) ? longint'(!st_in[1]) : 0;
        cs = longint'(cu);
        c = (ua >= ub + cu);
        full = ua - ub - cu;
        r = full[DW-1:0];
        sr = sa - sb - cs;
        v = (sr > MAXS) || (sr < MINS);
      end
      4'b0110: r = o.rn & v2;
      4'b0111: r = o.rn | v2;
      4'b1000: r = o.rn ^ v2;
      default: known = 1'b0;
    endcase
    st_out = st_in;
    if (o.s && known) st_out = {r[DW-1], (r == '0), c, v};
    e.res  = r;
    e.st   = o.rm;
    e.br   = DW'(longint'(o.pc) + longint'($signed(o.simm)) * 4);
    e.dest = o.dest;
    e.wb   = o.wb;
    e.mr   = o.mr;
    e.mw   = o.mw;
  endfunction

  function automatic op_t zero_op();
    op_t o;
    o.cmd = '0; o.wb = 0; o.mr = 0; o.mw = 0; o.imm = 0; o.s = 0;
    o.dest = '0; o.pc = '0; o.rn = '0; o.rm = '0; o.shop = '0; o.simm = '0;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.cmd = 4'($urandom_range(0, 15));
`ifdef EXE_MUL_EN
    if (o.cmd == 4'b1010) o.cmd = 4'b0011;
`endif
    o.wb   = 1'($urandom_range(0, 1));
    o.mr   = ($urandom_range(0, 7) == 0);
    o.mw   = ($urandom_range(0, 7) == 0);
    o.imm  = 1'($urandom_range(0, 1));
    o.s    = 1'($urandom_range(0, 1));
    o.dest = RW'($urandom);
    o.pc   = $urandom;
    case ($urandom_range(0, 5))
      0:       o.rn = 32'h8000_0000;
      1:       o.rn = 32'h7FFF_FFFF;
      default: o.rn = $urandom;
    endcase
    case ($urandom_range(0, 5))
      0:       o.rm = 32'hFFFF_FFFF;
      1:       o.rm = 32'h0;
      default: o.rm = $urandom;
    endcase
    o.shop = 12'($urandom);
    o.simm = 24'($urandom);
    return o;
  endfunction

  // ---------------- driver tasks
  task automatic drive_op(input op_t o);
    exe_cmd = o.cmd; wb_en = o.wb; mem_r_en = o.mr; mem_w_en = o.mw;
    imm = o.imm; s_bit = o.s; dest = o.dest; pc = o.pc; val_rn = o.rn;
    val_rm = o.rm; shift_operand = o.shop; signed_imm_24 = o.simm;
  endtask

  // Present one op at a falling edge, return at the falling edge after it is taken
  task automatic send_op(input op_t o);
    @(negedge clk);
    drive_op(o);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // ---------------- tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({out_valid, busy, wb_en_o, mem_r_en_o, mem_w_en_o} !== 5'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b want 00000", {out_valid, busy, wb_en_o, mem_r_en_o, mem_w_en_o});
    end
    vec_cnt++;
    if ({alu_result, st_val, br_addr, dest_o} !== '0) begin
      err_cnt++;
      $display("FAIL reset_data: got %h %h %h %h want all 0", alu_result, st_val, br_addr, dest_o);
    end
    vec_cnt++;
    if (status !== 4'b0000 || state !== S_IDLE) begin
      err_cnt++;
      $display("FAIL reset_status: got status %b state %0d want 0000 / IDLE", status, state);
    end
    rst = 1'b0;
    mdl_status = 4'b0000;
    @(negedge clk);
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    op_t o;
    exp_t e;
    logic [3:0] nst;
    // ADD 5 + rotated immediate 3
    o = zero_op(); o.cmd = CMD_ADD; o.rn = 5; o.imm = 1; o.shop = 12'h003; o.s = 1;
    send_op(o);
    ref_op(o, mdl_status, e, nst); mdl_status = nst;
    vec_cnt++;
    if (out_valid !== 1'b1 || alu_result !== 32'd8 || status !== 4'b0000) begin
      err_cnt++;
      $display("FAIL add_imm: got v=%b res=%h st=%b want v=1 res=8 st=0000", out_valid, alu_result, status);
    end
    // SUB 3 - 5
    o = zero_op(); o.cmd = CMD_SUB; o.rn = 3; o.imm = 1; o.shop = 12'h005; o.s = 1;
    send_op(o);
    ref_op(o, mdl_status, e, nst); mdl_status = nst;
    vec_cnt++;
    if (alu_result !== 32'hFFFF_FFFE || status !== 4'b1000 || status !== mdl_status) begin
      err_cnt++;
      $display("FAIL sub_neg: got res=%h st=%b want FFFFFFFE 1000", alu_result, status);
    end
    // MOV rotated immediate, flags held
    o = zero_op(); o.cmd = CMD_MOV; o.imm = 1; o.shop = 12'h4FF; o.rm = 32'h1234_5678;
    o.pc = 32'h100; o.simm = 24'hFFFFFF; o.dest = 4'hA; o.wb = 1;
    send_op(o);
    ref_op(o, mdl_status, e, nst); mdl_status = nst;
    vec_cnt++;
    if (alu_result !== 32'hFF00_0000 || status !== 4'b1000) begin
      err_cnt++;
      $display("FAIL mov_rot: got res=%h st=%b want FF000000 1000", alu_result, status);
    end
    vec_cnt++;
    if (br_addr !== 32'h0000_00FC || st_val !== 32'h1234_5678 || dest_o !== 4'hA || wb_en_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL br_st: got br=%h st=%h dest=%h wb=%b want FC 12345678 A 1", br_addr, st_val, dest_o, wb_en_o);
    end
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL drain_empty: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    op_t a, b;
    exp_t ea, eb;
    logic [3:0] nst;
    a = rand_op(); b = rand_op();
    ref_op(a, mdl_status, ea, nst); mdl_status = nst;
    ref_op(b, mdl_status, eb, nst); mdl_status = nst;
    @(negedge clk);
    drive_op(a); in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    drive_op(b);
    for (int i = 0; i < 3; i++) begin
      #1;
      vec_cnt++;
      if (out_valid !== 1'b1 || alu_result !== ea.res || br_addr !== ea.br || in_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL hold_%0d: got v=%b res=%h br=%h rdy=%b want 1 %h %h 0",
                 i, out_valid, alu_result, br_addr, in_ready, ea.res, ea.br);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL release_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b1 || alu_result !== eb.res || st_val !== eb.st || status !== mdl_status) begin
      err_cnt++;
      $display("FAIL next_op: got v=%b res=%h st=%b want 1 %h %b", out_valid, alu_result, status, eb.res, mdl_status);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    op_t o;
    exp_t e;
    logic [3:0] nst;
    logic [DW-1:0] exp_q[$];
    int sent = 0;
    int got = 0;
    logic [DW-1:0] want;
    @(negedge clk);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (out_valid === 1'b1) begin
        got++;
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL b2b_extra: got res=%h want no output", alu_result);
        end else begin
          want = exp_q.pop_front();
          if (alu_result !== want) begin
            err_cnt++;
            $display("FAIL b2b_res: got %h want %h", alu_result, want);
          end
        end
      end
      if (sent < 8) begin
        o = rand_op();
        drive_op(o);
        in_valid = 1'b1;
        #1;
        vec_cnt++;
        if (in_ready !== 1'b1) begin
          err_cnt++;
          $display("FAIL b2b_ready_%0d: got %b want 1", sent, in_ready);
        end
        ref_op(o, mdl_status, e, nst);
        mdl_status = nst;
        exp_q.push_back(e.res);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc == 8) begin
        vec_cnt++;
        if (got !== 8) begin
          err_cnt++;
          $display("FAIL b2b_rate: got %0d results in 9 cycles want 8", got);
        end
      end
    end
    vec_cnt++;
    if (exp_q.size() != 0 || status !== mdl_status) begin
      err_cnt++;
      $display("FAIL b2b_end: got left=%0d st=%b want 0 %b", exp_q.size(), status, mdl_status);
    end
  endtask

  task automatic test_random();
    op_t o;
    exp_t e, cur;
    logic [3:0] nst;
    logic mdl_valid = 1'b0;
    logic exp_rdy, fl, iv, ordy;
    cur.res = '0; cur.st = '0; cur.br = '0; cur.dest = '0; cur.wb = 0; cur.mr = 0; cur.mw = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      vec_cnt++;
      if (out_valid !== mdl_valid || status !== mdl_status) begin
        err_cnt++;
        $display("FAIL rnd_state c%0d: got v=%b st=%b want %b %b", cyc, out_valid, status, mdl_valid, mdl_status);
      end
      if (mdl_valid) begin
        vec_cnt++;
        if (alu_result !== cur.res || br_addr !== cur.br || st_val !== cur.st ||
            dest_o !== cur.dest || {wb_en_o, mem_r_en_o, mem_w_en_o} !== {cur.wb, cur.mr, cur.mw}) begin
          err_cnt++;
          $display("FAIL rnd_out c%0d: got %h %h %h %h want %h %h %h %h", cyc,
                   alu_result, br_addr, st_val, dest_o, cur.res, cur.br, cur.st, cur.dest);
        end
      end
      o = rand_op();
      drive_op(o);
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 19) == 0);
      in_valid = iv; out_ready = ordy; flush = fl;
      exp_rdy = (!mdl_valid || ordy) && !fl;
      #1;
      vec_cnt++;
      if (in_ready !== exp_rdy) begin
        err_cnt++;
        $display("FAIL rnd_ready c%0d: got %b want %b", cyc, in_ready, exp_rdy);
      end
      @(posedge clk);
      if (fl) begin
        mdl_valid = 1'b0;
      end else if (iv && exp_rdy) begin
        ref_op(o, mdl_status, e, nst);
        mdl_status = nst;
        cur = e;
        mdl_valid = 1'b1;
      end else if (ordy) begin
        mdl_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_unknown_cmd();
    op_t o;
    exp_t e;
    logic [3:0] nst;
    logic [3:0] code;
    for (int i = 0; i < 3; i++) begin
`ifdef EXE_MUL_EN
      code = (i == 0) ? 4'b0000 : (i == 1) ? 4'b1011 : 4'b1111;
`else
      code = (i == 0) ? 4'b0000 : (i == 1) ? 4'b1011 : 4'b1010;
`endif
      o = rand_op(); o.cmd = code; o.s = 1'b1;
      send_op(o);
      ref_op(o, mdl_status, e, nst); mdl_status = nst;
      vec_cnt++;
      if (out_valid !== 1'b1 || alu_result !== '0 || status !== mdl_status || busy !== 1'b0) begin
        err_cnt++;
        $display("FAIL unknown_%h: got v=%b res=%h st=%b busy=%b want 1 0 %b 0",
                 code, out_valid, alu_result, status, busy, mdl_status);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    op_t o;
    o = zero_op(); o.cmd = CMD_MVN; o.imm = 1; o.shop = 12'h001; o.s = 1;
    o.rm = 32'hDEAD_BEEF; o.pc = 32'h40; o.simm = 24'h10; o.wb = 1; o.mr = 1; o.dest = 4'h7;
    send_op(o);
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({out_valid, busy, wb_en_o, mem_r_en_o, mem_w_en_o, status} !== 9'b0 ||
        {alu_result, st_val, br_addr, dest_o} !== '0) begin
      err_cnt++;
      $display("FAIL async_reset: got v=%b st=%b res=%h br=%h want all 0", out_valid, status, alu_result, br_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    mdl_status = 4'b0000;
`ifdef EXE_MUL_EN
    o = zero_op(); o.cmd = CMD_MUL; o.rn = 9; o.imm = 1; o.shop = 12'h009;
    send_op(o);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (out_valid === 1'b1 || busy === 1'b1) seen++;
        @(negedge clk);
      end
      vec_cnt++;
      if (seen != 0) begin
        err_cnt++;
        $display("FAIL reset_mul: got %0d active cycles want 0", seen);
      end
    end
`endif
  endtask

`ifdef EXE_MUL_EN
  task automatic test_mul();
    op_t o;
    int busy_cycles = 0;
    int seen = 0;
    logic [3:0] st_before;
    o = zero_op(); o.cmd = CMD_MUL; o.rn = 7; o.imm = 1; o.shop = 12'h006; o.s = 1; o.dest = 4'h3;
    send_op(o);
    for (int i = 0; i < 100 && out_valid !== 1'b1; i++) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    mdl_status = {2'b00, mdl_status[1:0]};
    vec_cnt++;
    if (out_valid !== 1'b1 || busy_cycles != DW || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL mul_latency: got v=%b busy_cycles=%0d want 1 %0d", out_valid, busy_cycles, DW);
    end
    vec_cnt++;
    if (alu_result !== 32'd42 || status !== mdl_status || dest_o !== 4'h3) begin
      err_cnt++;
      $display("FAIL mul_result: got %h st=%b want 0000002a %b", alu_result, status, mdl_status);
    end
    // second multiply, flushed part way through
    st_before = status;
    send_op(o);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vec_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || state !== S_IDLE || status !== st_before) begin
      err_cnt++;
      $display("FAIL mul_flush: got busy=%b v=%b st=%b want 0 0 %b", busy, out_valid, status, st_before);
    end
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    vec_cnt++;
    if (seen != 0) begin
      err_cnt++;
      $display("FAIL mul_flush_quiet: got %0d valid cycles want 0", seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_unknown_cmd();
    test_random();
`ifdef EXE_MUL_EN
    test_mul();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
